// File: rtl/seg_scan_driver.sv
// Eight-digit common-anode seven-segment scanner with per-slot blanking and
// once-per-frame input snapshot. All outputs are registered (active-low).
module seg_scan_driver #(
    parameter int unsigned SLOT_CYCLES  = 4096,
    parameter int unsigned BLANK_CYCLES = 64
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [7:0]  EN,
    input  logic [63:0] DIGITS,
    input  logic [7:0]  DP,
    output logic [7:0]  SEG_AN,
    output logic        SEG_CA,
    output logic        SEG_CB,
    output logic        SEG_CC,
    output logic        SEG_CD,
    output logic        SEG_CE,
    output logic        SEG_CF,
    output logic        SEG_CG,
    output logic        SEG_DP,
    output logic        FRAME_TICK
);

    localparam int unsigned CW = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST    = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_W = CW'(BLANK_CYCLES);

    typedef enum logic {PH_BLANK, PH_DISPLAY} phase_e;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    en_s_q, en_s_d;
    logic [4:0]    codes_s_q [8];
    logic [4:0]    codes_s_d [8];
    logic [7:0]    dp_s_q, dp_s_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          segdp_q, segdp_d;
    logic          tick_q, tick_d;
    logic          last_cnt, load;
    phase_e        phase;
    logic [23:0]   unused_digit_hi;
    logic          unused_ok;

    // Active-low {A,B,C,D,E,F,G}; codes 24-31 fall into the blank default.
    function automatic logic [6:0] decode(input logic [4:0] c);
        case (c)
            5'd0:  decode = 7'b0000001;
            5'd1:  decode = 7'b1001111;
            5'd2:  decode = 7'b0010010;
            5'd3:  decode = 7'b0000110;
            5'd4:  decode = 7'b1001100;
            5'd5:  decode = 7'b0100100;
            5'd6:  decode = 7'b0100000;
            5'd7:  decode = 7'b0001111;
            5'd8:  decode = 7'b0000000;
            5'd9:  decode = 7'b0000100;
            5'd10: decode = 7'b0001000;
            5'd11: decode = 7'b1100000;
            5'd12: decode = 7'b0110001;
            5'd13: decode = 7'b1000010;
            5'd14: decode = 7'b0110000;
            5'd15: decode = 7'b0111000;
            5'd17: decode = 7'b1111110;
            5'd18: decode = 7'b1001000;
            5'd19: decode = 7'b1110001;
            5'd20: decode = 7'b0011000;
            5'd21: decode = 7'b1111010;
            5'd22: decode = 7'b1100010;
            5'd23: decode = 7'b1000001;
            default: decode = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        last_cnt = (cnt_q == LAST);
        load     = last_cnt && (idx_q == 3'd7);

        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (last_cnt) begin
            cnt_d = '0;
            idx_d = idx_q + 1'b1;
        end

        en_s_d    = en_s_q;
        codes_s_d = codes_s_q;
        dp_s_d    = dp_s_q;
        if (load) begin
            en_s_d = EN;
            dp_s_d = DP;
            for (int unsigned i = 0; i < 8; i++) begin
                codes_s_d[i] = DIGITS[8*i +: 5];
            end
        end
        tick_d = load;

        phase = ((BLANK_CYCLES != 0) && (cnt_q < BLANK_W)) ? PH_BLANK : PH_DISPLAY;

        an_d    = '1;
        seg_d   = '1;
        segdp_d = 1'b1;
        if (phase == PH_DISPLAY && en_s_q[idx_q]) begin
            an_d    = ~(8'b1 << idx_q);
            seg_d   = decode(codes_s_q[idx_q]);
            segdp_d = ~dp_s_q[idx_q];
        end
    end

    // Upper three bits of each digit byte carry no meaning.
    always_comb begin
        for (int unsigned i = 0; i < 8; i++) begin
            unused_digit_hi[3*i +: 3] = DIGITS[8*i+5 +: 3];
        end
    end
    assign unused_ok = ^unused_digit_hi;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            en_s_q    <= '0;
            codes_s_q <= '{default: '0};
            dp_s_q    <= '0;
            an_q      <= '1;
            seg_q     <= '1;
            segdp_q   <= 1'b1;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            en_s_q    <= en_s_d;
            codes_s_q <= codes_s_d;
            dp_s_q    <= dp_s_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            segdp_q   <= segdp_d;
            tick_q    <= tick_d;
        end
    end

    assign SEG_AN = an_q;
    assign {SEG_CA, SEG_CB, SEG_CC, SEG_CD, SEG_CE, SEG_CF, SEG_CG} = seg_q;
    assign SEG_DP     = segdp_q;
    assign FRAME_TICK = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: two instances (8-cycle slots, blank 2 and
// blank 0) share stimulus; outputs are sampled 1 time unit after each rising edge.
module tb_seg_scan_driver;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [7:0]  EN = 8'h00;
    logic [7:0]  DP = 8'h00;
    logic [63:0] DIGITS = 64'h0;

    logic [7:0] an_a, an_b;
    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b, tick_a, tick_b;

    int vectors = 0;
    int errors  = 0;
    int k = 0;

    logic [6:0] hex7 [8] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111};

    seg_scan_driver #(.SLOT_CYCLES(8), .BLANK_CYCLES(2)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .EN(EN), .DIGITS(DIGITS), .DP(DP),
        .SEG_AN(an_a), .SEG_CA(seg_a[6]), .SEG_CB(seg_a[5]), .SEG_CC(seg_a[4]),
        .SEG_CD(seg_a[3]), .SEG_CE(seg_a[2]), .SEG_CF(seg_a[1]), .SEG_CG(seg_a[0]),
        .SEG_DP(dp_a), .FRAME_TICK(tick_a)
    );

    seg_scan_driver #(.SLOT_CYCLES(8), .BLANK_CYCLES(0)) dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .EN(EN), .DIGITS(DIGITS), .DP(DP),
        .SEG_AN(an_b), .SEG_CA(seg_b[6]), .SEG_CB(seg_b[5]), .SEG_CC(seg_b[4]),
        .SEG_CD(seg_b[3]), .SEG_CE(seg_b[2]), .SEG_CF(seg_b[1]), .SEG_CG(seg_b[0]),
        .SEG_DP(dp_b), .FRAME_TICK(tick_b)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
        k++;
    endtask

    task automatic test_reset();
        EN = 8'hFF; DP = 8'h00; DIGITS = 64'h0706050403020100;
        HRESETn = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        vectors++; if (an_a !== 8'hFF) begin errors++; $display("FAIL reset_an actual=%h required=ff", an_a); end
        vectors++; if (seg_a !== 7'h7F) begin errors++; $display("FAIL reset_seg actual=%b required=1111111", seg_a); end
        vectors++; if (dp_a !== 1'b1) begin errors++; $display("FAIL reset_dp actual=%b required=1", dp_a); end
        vectors++; if (tick_a !== 1'b0) begin errors++; $display("FAIL reset_tick actual=%b required=0", tick_a); end
        vectors++; if (an_b !== 8'hFF) begin errors++; $display("FAIL reset_an_b0 actual=%h required=ff", an_b); end
        @(negedge HCLK);
        HRESETn = 1'b1;
        k = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            vectors++; if (an_a !== 8'hFF) begin errors++; $display("FAIL dark_frame_an k=%0d actual=%h required=ff", k, an_a); end
            vectors++; if (an_b !== 8'hFF) begin errors++; $display("FAIL dark_frame_an_b0 k=%0d actual=%h required=ff", k, an_b); end
            vectors++; if (tick_a !== (k == 64)) begin errors++; $display("FAIL frame_tick k=%0d actual=%b required=%b", k, tick_a, k == 64); end
        end
    endtask

    task automatic test_steady_scan();
        int c, slot, pos;
        logic [7:0] ean;
        logic [6:0] eseg;
        for (int i = 0; i < 64; i++) begin
            tick();
            c = k - 1; slot = (c / 8) % 8; pos = c % 8;
            ean  = (pos < 2) ? 8'hFF : ~(8'b1 << slot);
            eseg = (pos < 2) ? 7'h7F : hex7[slot];
            vectors++; if (an_a !== ean) begin errors++; $display("FAIL scan_an k=%0d actual=%h required=%h", k, an_a, ean); end
            vectors++; if (seg_a !== eseg) begin errors++; $display("FAIL scan_seg k=%0d actual=%b required=%b", k, seg_a, eseg); end
            vectors++; if (dp_a !== 1'b1) begin errors++; $display("FAIL scan_dp k=%0d actual=%b required=1", k, dp_a); end
            vectors++; if (tick_a !== (k == 128)) begin errors++; $display("FAIL scan_tick k=%0d actual=%b required=%b", k, tick_a, k == 128); end
        end
    endtask

    task automatic test_tearing();
        int c, slot, pos;
        logic [7:0] ean;
        logic [6:0] eseg;
        for (int i = 0; i < 64; i++) begin
            tick();
            c = k - 1; slot = (c / 8) % 8; pos = c % 8;
            ean  = (pos < 2) ? 8'hFF : ~(8'b1 << slot);
            eseg = (pos < 2) ? 7'h7F : hex7[slot];
            vectors++; if (an_a !== ean) begin errors++; $display("FAIL tear_old_an k=%0d actual=%h required=%h", k, an_a, ean); end
            vectors++; if (seg_a !== eseg) begin errors++; $display("FAIL tear_old_seg k=%0d actual=%b required=%b", k, seg_a, eseg); end
            if (k == 155) DIGITS = {8{8'h11}};
        end
        for (int i = 0; i < 64; i++) begin
            tick();
            c = k - 1; slot = (c / 8) % 8; pos = c % 8;
            ean  = (pos < 2) ? 8'hFF : ~(8'b1 << slot);
            eseg = (pos < 2) ? 7'h7F : 7'b1111110;
            vectors++; if (an_a !== ean) begin errors++; $display("FAIL tear_new_an k=%0d actual=%h required=%h", k, an_a, ean); end
            vectors++; if (seg_a !== eseg) begin errors++; $display("FAIL tear_new_seg k=%0d actual=%b required=%b", k, seg_a, eseg); end
        end
    endtask

    task automatic test_enable_dp();
        int c, slot, pos;
        logic lit;
        logic [7:0] ean;
        logic [6:0] eseg;
        EN = 8'h05; DP = 8'h04;
        repeat (64) tick();
        for (int i = 0; i < 64; i++) begin
            tick();
            c = k - 1; slot = (c / 8) % 8; pos = c % 8;
            lit  = (pos >= 2) && (slot == 0 || slot == 2);
            ean  = lit ? ~(8'b1 << slot) : 8'hFF;
            eseg = lit ? 7'b1111110 : 7'h7F;
            vectors++; if (an_a !== ean) begin errors++; $display("FAIL en_an k=%0d actual=%h required=%h", k, an_a, ean); end
            vectors++; if (seg_a !== eseg) begin errors++; $display("FAIL en_seg k=%0d actual=%b required=%b", k, seg_a, eseg); end
            vectors++; if (dp_a !== !(lit && slot == 2)) begin errors++; $display("FAIL en_dp k=%0d actual=%b required=%b", k, dp_a, !(lit && slot == 2)); end
        end
    endtask

    task automatic test_special_codes();
        int c, slot, pos;
        logic lit;
        logic [7:0] ean;
        logic [6:0] eseg;
        DIGITS = 64'h0000_0000_001B_17F2;
        EN = 8'h07; DP = 8'h00;
        repeat (64) tick();
        for (int i = 0; i < 64; i++) begin
            tick();
            c = k - 1; slot = (c / 8) % 8; pos = c % 8;
            lit  = (pos >= 2) && (slot < 3);
            ean  = lit ? ~(8'b1 << slot) : 8'hFF;
            eseg = !lit ? 7'h7F : (slot == 0) ? 7'b1001000 : (slot == 1) ? 7'b1000001 : 7'b1111111;
            vectors++; if (an_a !== ean) begin errors++; $display("FAIL special_an k=%0d actual=%h required=%h", k, an_a, ean); end
            vectors++; if (seg_a !== eseg) begin errors++; $display("FAIL special_seg k=%0d actual=%b required=%b", k, seg_a, eseg); end
            vectors++; if (dp_a !== 1'b1) begin errors++; $display("FAIL special_dp k=%0d actual=%b required=1", k, dp_a); end
        end
    endtask

    task automatic test_async_reset();
        int c, slot, pos;
        logic [7:0] ean;
        logic [6:0] eseg;
        EN = 8'hFF; DP = 8'h00; DIGITS = 64'h0706050403020100;
        repeat (64) tick();
        repeat (37) tick();
        vectors++; if (an_a !== 8'hEF) begin errors++; $display("FAIL pre_reset_an actual=%h required=ef", an_a); end
        vectors++; if (an_b !== 8'hEF) begin errors++; $display("FAIL pre_reset_an_b0 actual=%h required=ef", an_b); end
        #2;
        HRESETn = 1'b0;
        #1;
        vectors++; if (an_a !== 8'hFF) begin errors++; $display("FAIL async_an actual=%h required=ff", an_a); end
        vectors++; if (an_b !== 8'hFF) begin errors++; $display("FAIL async_an_b0 actual=%h required=ff", an_b); end
        vectors++; if (seg_a !== 7'h7F) begin errors++; $display("FAIL async_seg actual=%b required=1111111", seg_a); end
        vectors++; if (seg_b !== 7'h7F) begin errors++; $display("FAIL async_seg_b0 actual=%b required=1111111", seg_b); end
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        k = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            vectors++; if (an_a !== 8'hFF) begin errors++; $display("FAIL redark_an k=%0d actual=%h required=ff", k, an_a); end
            vectors++; if (an_b !== 8'hFF) begin errors++; $display("FAIL redark_an_b0 k=%0d actual=%h required=ff", k, an_b); end
            vectors++; if (tick_b !== (k == 64)) begin errors++; $display("FAIL redark_tick_b0 k=%0d actual=%b required=%b", k, tick_b, k == 64); end
        end
        for (int i = 0; i < 64; i++) begin
            tick();
            c = k - 1; slot = (c / 8) % 8; pos = c % 8;
            vectors++; if (an_b !== ~(8'b1 << slot)) begin errors++; $display("FAIL noblank_an k=%0d actual=%h required=%h", k, an_b, ~(8'b1 << slot)); end
            vectors++; if (seg_b !== hex7[slot]) begin errors++; $display("FAIL noblank_seg k=%0d actual=%b required=%b", k, seg_b, hex7[slot]); end
            ean  = (pos < 2) ? 8'hFF : ~(8'b1 << slot);
            eseg = (pos < 2) ? 7'h7F : hex7[slot];
            vectors++; if (an_a !== ean) begin errors++; $display("FAIL rescan_an k=%0d actual=%h required=%h", k, an_a, ean); end
            vectors++; if (seg_a !== eseg) begin errors++; $display("FAIL rescan_seg k=%0d actual=%b required=%b", k, seg_a, eseg); end
        end
    endtask

    initial begin
        test_reset();
        test_steady_scan();
        test_tearing();
        test_enable_dp();
        test_special_codes();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Downstream consumer of the memory-mapped seven-segment register block.
- Takes the 8-digit enable mask, the 64-bit digit codes and the decimal-point mask.
- Time-multiplexes them onto the board's eight common-anode displays: one digit per slot, rows of segments shared.
- Adds a blanking interval at the start of every slot to suppress ghosting, and snapshots inputs once per frame so a frame never tears.

Parameters:
- SLOT_CYCLES, 4096: HCLK cycles per digit slot. Legal range 2..2^20.
- BLANK_CYCLES, 64: cycles at the start of each slot with all anodes off. Legal range 0..SLOT_CYCLES-1.

Ports:
- HCLK  in  1  system clock
- HRESETn  in  1  reset, asynchronous, active-low
- EN  in  8  bit i=1 enables digit i
- DIGITS  in  64  byte i = code for digit i; bits [4:0] used, [7:5] ignored
- DP  in  8  bit i=1 lights the decimal point of digit i
- SEG_AN  out  8  anodes, active-low, bit i = digit i
- SEG_CA..SEG_CG, SEG_DP  out  1 each  segments, active-low
- FRAME_TICK  out  1  one-cycle pulse when the snapshot loads

Behaviour:
- HRESETn is asynchronous and active-low; HCLK is the clock.
- Reset state:
  - Slot counter cnt=0, digit index idx=0.
  - Snapshot registers EN_s, DIGITS_s, DP_s = 0.
  - SEG_AN=8'hFF, all segment outputs =1, FRAME_TICK=0.
- Counting:
  - cnt increments each cycle, 0..SLOT_CYCLES-1.
  - At SLOT_CYCLES-1, cnt wraps to 0 and idx increments mod 8 (7 wraps to 0).
- Snapshot:
  - Loads on the cycle where idx==7 and cnt==SLOT_CYCLES-1: EN_s<=EN, DIGITS_s<=DIGITS, DP_s<=DP.
  - FRAME_TICK=1 on the cycle after that edge, exactly one cycle.
  - Input changes at any other time have no effect until the next frame. The first frame after reset is therefore fully dark.
- Slot phases, a function of the current (idx, cnt):
  - BLANK when cnt<BLANK_CYCLES: all anodes 1, all segments 1.
  - DISPLAY otherwise. If EN_s[idx]=0, output is as in BLANK. Else SEG_AN = ~(1<<idx), segments = decode(DIGITS_s[8*idx+4 : 8*idx]), SEG_DP = ~DP_s[idx].
- Latency: all outputs are registered, so they reflect the (idx, cnt) of the previous cycle (1 HCLK latency). No combinational path from inputs to outputs.
- Decode: active-low pattern {CA,CB,CC,CD,CE,CF,CG}.
  - Codes 0-15 are hex 0-F: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - 16=blank 1111111, 17='-' 1111110, 18='H' 1001000, 19='L' 1110001, 20='P' 0011000, 21='r' 1111010, 22='o' 1100010, 23='U' 1000001.
  - 24-31 = blank.
- At most one anode is low in any cycle. Never two.
- BLANK_CYCLES=0: no blank phase; each slot is entirely DISPLAY.
- Reset asserted mid-slot: outputs go to reset values immediately (asynchronous). On release, counting restarts at idx=0, cnt=0 and the dark first frame is repeated.

Test Plan:
1. Reset
   - Stimulus: SLOT_CYCLES=8, BLANK_CYCLES=2, EN=FF, DIGITS=64'h0706050403020100, DP=0; release reset.
   - Required: SEG_AN=FF for the first 64 cycles. FRAME_TICK pulses once at cycle 64.
2. Steady scan (same setup)
   - In frame 2, each slot shows 2 cycles with SEG_AN=FF, then 6 cycles with SEG_AN=~(1<<i).
   - Digit 0 segments = 0000001; digit 7 segments = 0001111.
   - Scan order 0..7, then wraps to 0.
3. Tearing protection
   - Stimulus: change DIGITS to all 8'h11 while idx=3.
   - Required: digits 3-7 keep their old codes. Next frame shows '-' (1111110) on all digits.
4. Enable mask and DP
   - Stimulus: EN=8'h05, DP=8'h04.
   - Required: only anodes 0 and 2 ever go low. SEG_DP=0 only while anode 2 is low. Slots 1 and 3-7 are fully dark.
5. Special codes
   - Stimulus: codes 18, 23 and 27.
   - Required: 1001000, 1000001, 1111111 respectively.
6. Asynchronous reset mid-slot
   - Stimulus: assert HRESETn=0 at idx=4, cnt=5, between clock edges.
   - Required: SEG_AN=FF immediately. After release, the first frame is dark again.
   - Also check with BLANK_CYCLES=0: anode is low for all 8 cycles of each slot.
